// File: rtl/fp_maxpool2x2.sv
// fp_maxpool2x2: 2x2 stride-2 max-pool over a row-major FP32 pixel stream.
// Even-row horizontal maxima wait in a half-width line buffer for the odd row.
module fp_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Clr,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d, dout_q, dout_d;
  logic                  vout_q, vout_d, fd_q, fd_d;
  logic [DATA_WIDTH-1:0] lb_q [IMG_W/2];
  logic [LW-1:0]         idx;
  logic [DATA_WIDTH-1:0] lb_rd, hmax, wmax;
  logic                  last_col, last_row, lb_we;
  // x strictly beats y; +0/-0 are equal, negatives order by smaller magnitude
  function automatic logic gt(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y);
    return (x[DATA_WIDTH-2:0] == '0 && y[DATA_WIDTH-2:0] == '0) ? 1'b0 :
           (x[DATA_WIDTH-1] != y[DATA_WIDTH-1]) ? !x[DATA_WIDTH-1] :
           x[DATA_WIDTH-1] ? (x[DATA_WIDTH-2:0] < y[DATA_WIDTH-2:0]) :
                             (x[DATA_WIDTH-2:0] > y[DATA_WIDTH-2:0]);
  endfunction
  assign idx      = LW'(col_q >> 1);
  assign lb_rd    = lb_q[idx];
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last_row = row_q == RW'(IMG_H - 1);
  assign hmax     = gt(Data_In, pair_q) ? Data_In : pair_q;
  assign wmax     = gt(hmax, lb_rd) ? hmax : lb_rd;
  assign lb_we    = Valid_In && !Clr && col_q[0] && !row_q[0];
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pair_d = pair_q;
    dout_d = dout_q;
    vout_d = 1'b0;
    fd_d   = 1'b0;
    if (Clr) begin
      col_d  = '0;
      row_d  = '0;
      pair_d = '0;
    end else if (Valid_In) begin
      col_d  = last_col ? '0 : col_q + 1'b1;
      row_d  = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
      pair_d = col_q[0] ? pair_q : Data_In;
      if (col_q[0] && row_q[0]) begin
        dout_d = wmax;
        vout_d = 1'b1;
        fd_d   = last_row && last_col;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      pair_q <= pair_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      fd_q   <= fd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[idx] <= hmax;
  end
  assign Data_Out   = dout_q;
  assign Valid_Out  = vout_q;
  assign Frame_Done = fd_q;
endmodule

// File: tb/tb_fp_maxpool2x2.sv
// tb_fp_maxpool2x2: directed 4x4 frames of hand-computed 2x2 windows, with gaps,
// back-to-back frames, async reset and Clr aborts.
module tb_fp_maxpool2x2;
  logic        clk = 1'b0, rst = 1'b0, Clr = 1'b0, Valid_In = 1'b0;
  logic [31:0] Data_In = '0;
  logic [31:0] Data_Out;
  logic        Valid_Out, Frame_Done;
  int          n_chk = 0, n_fail = 0, nv = 0, nf = 0, nv0, nf0;
  logic [31:0] exp_dout;
  typedef struct {
    logic [3:0][3:0][31:0] w;
    logic [3:0][31:0]      exp;
    int                    gap;
  } vec_t;
  vec_t tbl [5];
  fp_maxpool2x2 #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .Clr(Clr), .Data_In(Data_In), .Valid_In(Valid_In),
    .Data_Out(Data_Out), .Valid_Out(Valid_Out), .Frame_Done(Frame_Done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (Valid_Out) nv++;
    if (Frame_Done) nf++;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, req);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] d);
    Valid_In = v;
    Data_In  = d;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic setw(input int e, input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d, input logic [31:0] x);
    tbl[e].w[k][0] = a;
    tbl[e].w[k][1] = b;
    tbl[e].w[k][2] = c;
    tbl[e].w[k][3] = d;
    tbl[e].exp[k]  = x;
  endtask
  task automatic run(input vec_t v, input string tag);
    int r, c, win, ng;
    logic comp;
    for (int k = 0; k < 16; k++) begin
      r   = k / 4;
      c   = k % 4;
      win = (r / 2) * 2 + c / 2;
      ng  = (v.gap == 0) ? 0 : (v.gap == 1) ? int'(k > 0) : int'($urandom_range(0, 3));
      repeat (ng) begin
        cyc(1'b0, 32'hDEADBEEF);
        chk({tag, "_gap_valid"}, {31'b0, Valid_Out}, 32'd0);
        chk({tag, "_gap_hold"}, Data_Out, exp_dout);
      end
      cyc(1'b1, v.w[win][(r % 2) * 2 + c % 2]);
      comp = (r % 2 == 1) && (c % 2 == 1);
      chk({tag, "_valid"}, {31'b0, Valid_Out}, {31'b0, comp});
      chk({tag, "_fdone"}, {31'b0, Frame_Done}, {31'b0, comp && k == 15});
      if (comp) exp_dout = v.exp[win];
      chk({tag, "_data"}, Data_Out, exp_dout);
    end
  endtask
  initial begin
    setw(0, 0, 32'h3F800000, 32'h40000000, 32'h40A00000, 32'h40C00000, 32'h40C00000);
    setw(0, 1, 32'h40400000, 32'h40800000, 32'h40E00000, 32'h41000000, 32'h41000000);
    setw(0, 2, 32'h41100000, 32'h41200000, 32'h41500000, 32'h41600000, 32'h41600000);
    setw(0, 3, 32'h41300000, 32'h41400000, 32'h41700000, 32'h41800000, 32'h41800000);
    tbl[0].gap = 0;
    setw(1, 0, 32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hBF000000, 32'hBF000000);
    setw(1, 1, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000);
    setw(1, 2, 32'hC0000000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h3F800000);
    setw(1, 3, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h00000002, 32'h7FC00000);
    tbl[1].gap = 0;
    setw(2, 0, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000);
    setw(2, 1, 32'hFF800000, 32'hFF7FFFFF, 32'h80000001, 32'h80000002, 32'h80000001);
    setw(2, 2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    setw(2, 3, 32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
    tbl[2].gap = 0;
    tbl[3] = tbl[0];
    tbl[3].gap = 1;
    tbl[4] = tbl[0];
    tbl[4].gap = 2;
    repeat (2) @(negedge clk);
    chk("rst_data", Data_Out, 32'd0);
    chk("rst_valid", {31'b0, Valid_Out}, 32'd0);
    chk("rst_fdone", {31'b0, Frame_Done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    exp_dout = '0;
    for (int e = 0; e < 5; e++) run(tbl[e], $sformatf("vec%0d", e));
    cyc(1'b0, '0);
    nv0 = nv;
    nf0 = nf;
    run(tbl[0], "b2b_a");
    run(tbl[1], "b2b_b");
    repeat (2) cyc(1'b0, '0);
    chk("b2b_valid_cnt", nv - nv0, 32'd8);
    chk("b2b_fdone_cnt", nf - nf0, 32'd2);
    for (int k = 0; k < 5; k++) cyc(1'b1, tbl[0].w[k / 2][k % 2]);
    rst = 1'b0;
    #1;
    chk("midrst_data", Data_Out, 32'd0);
    chk("midrst_valid", {31'b0, Valid_Out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_dout = '0;
    run(tbl[0], "after_rst");
    for (int k = 0; k < 13; k++) cyc(1'b1, tbl[0].w[(k / 8) * 2 + (k % 4) / 2][((k / 4) % 2) * 2 + k % 2]);
    exp_dout = 32'h41000000;
    chk("preclr_data", Data_Out, exp_dout);
    Clr = 1'b1;
    cyc(1'b1, 32'h7F000000);
    Clr = 1'b0;
    chk("clr_valid", {31'b0, Valid_Out}, 32'd0);
    chk("clr_fdone", {31'b0, Frame_Done}, 32'd0);
    chk("clr_hold", Data_Out, exp_dout);
    run(tbl[0], "after_clr");
    cyc(1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
